// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, step opcodes
// and the {Q[0], q_1} recoding rule.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_t;

    function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_multiplier_seq_if.sv
// Request/result bundle of the Booth multiplier; master issues operands,
// slave returns busy/done/product. start is ignored while busy.
interface booth_multiplier_seq_if #(
    parameter int WIDTH = 8
) ();
    logic               start;
    logic               sgn;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (output start, sgn, a, b, input busy, done, product);
    modport slave  (input start, sgn, a, b, output busy, done, product);
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/sub M into Acc, then arithmetic shift of {Acc, Q, q_1}.
// Purely combinational; no handshake.
module booth_step
    import booth_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N:0]   acc,
    input  logic [N-1:0] q,
    input  logic         q_1,
    input  logic [N-1:0] m,
    output logic [N:0]   acc_nxt,
    output logic [N-1:0] q_nxt,
    output logic         q_1_nxt
);
    logic [N:0] m_ext;
    logic [N:0] sum;

    // The extra Acc bit keeps Acc - M representable even when M is most-negative.
    assign m_ext = {m[N-1], m};

    always_comb begin
        sum = acc;
        case (booth_decode(q[0], q_1))
            ADD:     sum = acc + m_ext;
            SUB:     sum = acc - m_ext;
            default: sum = acc;
        endcase
    end

    assign acc_nxt = {sum[N], sum[N:1]};
    assign q_nxt   = {sum[0], q[N-1:1]};
    assign q_1_nxt = q[0];

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential WIDTH x WIDTH Booth multiplier with runtime signed/unsigned mode.
// Latency WIDTH+1 steps after the start edge; start is ignored while busy.
module booth_multiplier_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    booth_multiplier_seq_if.slave bus
);
    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t             state;
    state_t             state_nxt;
    logic [N:0]         acc;
    logic [N-1:0]       q;
    logic               q_1;
    logic [N-1:0]       m;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] product;

    logic [N:0]         acc_nxt;
    logic [N-1:0]       q_nxt;
    logic               q_1_nxt;
    logic               load;
    logic               last;

    assign load = (state != RUN) && bus.start;
    assign last = (state == RUN) && (count == CNT_ONE);

    booth_step #(.N(N)) u_step (
        .acc     (acc),
        .q       (q),
        .q_1     (q_1),
        .m       (m),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt),
        .q_1_nxt (q_1_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    // Extending by one bit (sign or zero) lets a single signed datapath do both modes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            m       <= '0;
            count   <= '0;
            product <= '0;
        end else if (load) begin
            acc   <= '0;
            q     <= {bus.sgn & bus.b[WIDTH-1], bus.b};
            q_1   <= 1'b0;
            m     <= {bus.sgn & bus.a[WIDTH-1], bus.a};
            count <= CNT_INIT;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            q     <= q_nxt;
            q_1   <= q_1_nxt;
            count <= count - CNT_ONE;
            if (last) product <= {acc_nxt[WIDTH-2:0], q_nxt};
        end
    end

    assign bus.product = product;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Scoreboard bench for booth_multiplier_seq (WIDTH=8): driver pushes expected
// products, a negedge monitor pops and checks value, latency and hold behaviour.
module tb_booth_multiplier_seq;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    booth_multiplier_seq_if #(.WIDTH(8)) bus ();

    booth_multiplier_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic s, input logic [7:0] x, input logic [7:0] y);
        int ix;
        int iy;
        ix = s ? int'($signed(x)) : int'(x);
        iy = s ? int'($signed(y)) : int'(y);
        return 16'(ix * iy);
    endfunction

    // Waits for an idle slot, issues one operation and records its expectation.
    task automatic do_op(input logic s, input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] e, input bit keep);
        int t;
        t = 0;
        @(negedge clk);
        while (bus.busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("idle_wait_timeout", {31'd0, bus.busy}, 32'd0);
        bus.sgn   = s;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{e, cyc});
        if (!keep) bus.start = 1'b0;
        bus.a   = 8'($urandom);
        bus.b   = 8'($urandom);
        bus.sgn = 1'($urandom);
    endtask

    // Monitor: pops on done, otherwise requires the product to hold its last value.
    initial begin : monitor
        logic [15:0] last_product;
        int          busy_len;
        logic        prev_done;
        exp_t        e;
        last_product = '0;
        busy_len     = 0;
        prev_done    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_product = '0;
                busy_len     = 0;
                prev_done    = 1'b0;
            end else begin
                if (bus.done) begin
                    check("done_single_cycle", {31'd0, prev_done}, 32'd0);
                    check("busy_low_at_done", {31'd0, bus.busy}, 32'd0);
                    check("busy_length", 32'(busy_len), 32'd9);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got product %0h with empty scoreboard", bus.product);
                    end else begin
                        e = sb.pop_front();
                        check("product", {16'd0, bus.product}, {16'd0, e.prod});
                        check("latency", 32'(cyc - e.cyc), 32'd9);
                        last_product = e.prod;
                    end
                    busy_len = 0;
                end else begin
                    check("product_hold", {16'd0, bus.product}, {16'd0, last_product});
                    if (bus.busy) busy_len++;
                end
                prev_done = bus.done;
            end
        end
    end

    initial begin
        int t;
        logic s;
        logic [7:0] x;
        logic [7:0] y;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sgn   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #1;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_product", {16'd0, bus.product}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        do_op(1'b1, 8'h07, 8'hFD, 16'hFFEB, 1'b0);
        do_op(1'b1, 8'h80, 8'h80, 16'h4000, 1'b0);
        do_op(1'b1, 8'h80, 8'h7F, 16'hC080, 1'b0);
        do_op(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
        do_op(1'b0, 8'h80, 8'h02, 16'h0100, 1'b0);
        do_op(1'b1, 8'h80, 8'h02, 16'hFF00, 1'b0);
        do_op(1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0);
        do_op(1'b1, 8'h7F, 8'h7F, 16'h3F01, 1'b0);
        do_op(1'b0, 8'h12, 8'h34, 16'h03A8, 1'b0);

        // start held high across three back-to-back operations
        do_op(1'b1, 8'd3, 8'd4, 16'd12, 1'b1);
        do_op(1'b1, 8'd5, 8'd6, 16'd30, 1'b1);
        do_op(1'b1, 8'd0, 8'd9, 16'd0, 1'b0);

        // start pulses during RUN must be ignored
        do_op(1'b0, 8'd10, 8'd11, 16'd110, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h66;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        // Reset in the middle of an operation
        t = 0;
        @(negedge clk);
        while ((bus.busy || sb.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("pre_reset_drain", 32'(sb.size()), 32'd0);
        bus.sgn   = 1'b0;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", {31'd0, bus.busy}, 32'd0);
        check("midrun_reset_done", {31'd0, bus.done}, 32'd0);
        check("midrun_reset_product", {16'd0, bus.product}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 8'd2, 8'd3, 16'd6, 1'b0);

        // Random operands against the reference model
        for (int i = 0; i < 1500; i++) begin
            s = 1'($urandom);
            x = 8'($urandom);
            y = 8'($urandom);
            do_op(s, x, y, ref_mul(s, x, y), 1'($urandom_range(0, 3) == 0));
        end
        bus.start = 1'b0;

        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
